// File: rtl/dac_reg_spi_responder_pkg.sv
// Shared encodings for the DAC/register SPI responder: chip-select patterns,
// range codes and the responder FSM state type.
package dac_reg_spi_responder_pkg;

  localparam logic [1:0] CS_NONE = 2'b11;
  localparam logic [1:0] CS_DAC  = 2'b01;
  localparam logic [1:0] CS_REG  = 2'b10;
  localparam logic [1:0] CS_BOTH = 2'b00;

  localparam logic [2:0] DIAP_5V  = 3'b001;
  localparam logic [2:0] DIAP_10V = 3'b010;
  localparam logic [2:0] DIAP_20V = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  typedef enum logic {
    TGT_DAC = 1'b0,
    TGT_REG = 1'b1
  } tgt_e;

endpackage

// File: rtl/dac_reg_spi_responder_spi_in_sync.sv
// Brings sck, mosi and cs_n into the clk domain through SYNC_STAGES flops and
// derives single-cycle edge pulses for sck and the cs_n falling edge.
module spi_in_sync
  import dac_reg_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic [1:0] cs_n_i,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       mosi_o,
  output logic [1:0] cs_n_o,
  output logic       cs_fall_o
);

  // Per-stage bundle: {cs_n[1:0], mosi, sck}
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] last;
  logic       sck_prev_q;
  logic [1:0] cs_prev_q;

  // cs_n resets to 00 ("bus not known idle"), so a select already held low
  // through reset is never mistaken for a new frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= CS_BOTH;
    end else begin
      sync_q[0] <= {cs_n_i, mosi_i, sck_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_prev_q <= last[0];
      cs_prev_q  <= last[3:2];
    end
  end

  assign last       = sync_q[SYNC_STAGES-1];
  assign sck_rise_o = last[0] & ~sck_prev_q;
  assign sck_fall_o = ~last[0] & sck_prev_q;
  assign mosi_o     = last[1];
  assign cs_n_o     = last[3:2];
  assign cs_fall_o  = (cs_prev_q == CS_NONE) && (last[3:2] != CS_NONE);

endmodule

// File: rtl/dac_reg_spi_responder.sv
// SPI mode-0 target for the DAC/register link: shifts in MSB-first frames,
// commits complete frames to the DAC code or range/key register, reads back the old value.
module dac_reg_spi_responder
  import dac_reg_spi_responder_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0] DAC_RST_CODE = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [1:0]            cs_n_i,
  output logic [DATA_WIDTH-1:0] dac_code_o,
  output logic                  dac_update_o,
  output logic [2:0]            diap_o,
  output logic [4:0]            keys_o,
  output logic                  reg_update_o,
  output logic                  frame_err_o,
  output state_e                state_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic       sck_rise, sck_fall, mosi_s, cs_fall;
  logic [1:0] cs_s;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (sck_i),
    .mosi_i     (mosi_i),
    .cs_n_i     (cs_n_i),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .mosi_o     (mosi_s),
    .cs_n_o     (cs_s),
    .cs_fall_o  (cs_fall)
  );

  state_e                state_q, state_d;
  tgt_e                  tgt_q, tgt_d;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_q, tx_q, dac_code_q;
  logic [2:0]            diap_q;
  logic [4:0]            keys_q;
  logic                  commit_dac_q, commit_reg_q;
  logic                  dac_update_q, reg_update_q, frame_err_q;

  logic                  load_tx, rx_shift, tx_shift, err_d;
  logic                  commit_dac_d, commit_reg_d;
  logic [1:0]            own_cs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_DAC;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    load_tx      = 1'b0;
    rx_shift     = 1'b0;
    tx_shift     = 1'b0;
    err_d        = 1'b0;
    commit_dac_d = 1'b0;
    commit_reg_d = 1'b0;
    own_cs       = (tgt_q == TGT_DAC) ? CS_DAC : CS_REG;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          if (cs_s == CS_DAC) begin
            state_d = ST_SHIFT;
            tgt_d   = TGT_DAC;
            load_tx = 1'b1;
          end else if (cs_s == CS_REG) begin
            state_d = ST_SHIFT;
            tgt_d   = TGT_REG;
            load_tx = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_s == CS_NONE) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cs_s != own_cs) begin
          state_d = ST_ERROR;
        end else begin
          if (sck_rise) begin
            rx_shift = 1'b1;
            if (bit_cnt_q == CW'(DATA_WIDTH - 1)) state_d = ST_HOLD;
          end
          if (sck_fall) tx_shift = 1'b1;
        end
      end
      ST_HOLD: begin
        // The commit itself lands one cycle later, from the commit_*_q flags.
        if (cs_s == CS_NONE) begin
          commit_dac_d = (tgt_q == TGT_DAC);
          commit_reg_d = (tgt_q == TGT_REG);
          state_d      = ST_IDLE;
        end else if (cs_s != own_cs || sck_rise) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (cs_s == CS_NONE) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      dac_code_q   <= DAC_RST_CODE;
      diap_q       <= 3'b000;
      keys_q       <= 5'b00000;
      commit_dac_q <= 1'b0;
      commit_reg_q <= 1'b0;
      dac_update_q <= 1'b0;
      reg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (load_tx) begin
        bit_cnt_q <= '0;
        tx_q      <= (tgt_d == TGT_DAC) ? dac_code_q : DATA_WIDTH'({diap_q, keys_q});
      end
      if (rx_shift) begin
        rx_q      <= {rx_q[DATA_WIDTH-2:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (tx_shift) tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
      commit_dac_q <= commit_dac_d;
      commit_reg_q <= commit_reg_d;
      dac_update_q <= commit_dac_q;
      reg_update_q <= commit_reg_q;
      frame_err_q  <= err_d;
      if (commit_dac_q) dac_code_q <= rx_q;
      // Range bits are stored as received; one-hot is the host's responsibility.
      if (commit_reg_q) begin
        diap_q <= rx_q[DATA_WIDTH-1 -: 3];
        keys_q <= rx_q[4:0];
      end
    end
  end

  assign miso_o       = tx_q[DATA_WIDTH-1];
  assign dac_code_o   = dac_code_q;
  assign dac_update_o = dac_update_q;
  assign diap_o       = diap_q;
  assign keys_o       = keys_q;
  assign reg_update_o = reg_update_q;
  assign frame_err_o  = frame_err_q;
  assign state_o      = state_q;

endmodule
